// File: rtl/draw_stopwatch.sv
// VGA overlay stage: draws the stopwatch time as "MM:SS" in 7-segment glyphs.
// The time is snapshotted once per frame (on vs rise) and converted to BCD sequentially.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_stopwatch #(
  parameter int          X_POS   = 16,
  parameter int          Y_POS   = 16,
  parameter int          DIGIT_W = 24,
  parameter int          DIGIT_H = 40,
  parameter int          SEG_T   = 4,
  parameter int          GAP     = 8,
  parameter logic [11:0] COLOR   = 12'hFF0
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [5:0]               minutes,
  input  logic [5:0]               seconds,
  input  logic [`VGA_BUS_SIZE-1:0] vga_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_out
);

  localparam int P = DIGIT_W + GAP;
  localparam logic [10:0] X0 = 11'(X_POS);
  localparam logic [10:0] X1 = 11'(X_POS + P);
  localparam logic [10:0] XC = 11'(X_POS + 2 * P);
  localparam logic [10:0] X2 = 11'(X_POS + 2 * P + SEG_T + GAP);
  localparam logic [10:0] X3 = 11'(X_POS + 3 * P + SEG_T + GAP);
  localparam logic [10:0] Y0 = 11'(Y_POS);
  localparam logic [10:0] W  = 11'(DIGIT_W);
  localparam logic [10:0] H  = 11'(DIGIT_H);
  localparam logic [10:0] T  = 11'(SEG_T);
  localparam logic [10:0] HALF    = 11'(DIGIT_H / 2);
  localparam logic [10:0] D_START = 11'(DIGIT_H - SEG_T);
  localparam logic [10:0] R_START = 11'(DIGIT_W - SEG_T);
  localparam logic [10:0] G_START = 11'(DIGIT_H / 2 - SEG_T / 2);
  localparam logic [10:0] G_END   = 11'(DIGIT_H / 2 + SEG_T / 2);
  localparam logic [10:0] C0_START = 11'(DIGIT_H / 4 - SEG_T / 2);
  localparam logic [10:0] C0_END   = 11'(DIGIT_H / 4 + SEG_T / 2);
  localparam logic [10:0] C1_START = 11'(3 * DIGIT_H / 4 - SEG_T / 2);
  localparam logic [10:0] C1_END   = 11'(3 * DIGIT_H / 4 + SEG_T / 2);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t state, state_next;

  logic       vs_prev, vs_edge;
  logic [5:0] m_s, s_s;
  logic [2:0] m_tens, s_tens;
  logic [3:0] d0, d1, d2, d3;

  logic [`VGA_BUS_SIZE-1:0] bus_s1;
  logic [4:0]               hit, hit_s1;
  logic                     en_s1, draw;

  assign vs_edge = vga_in[37] & ~vs_prev;

  // Segment mask is {a,b,c,d,e,f,g}; the bounding-box test gates the relative coordinates.
  function automatic logic digit_hit(input logic [10:0] hc, input logic [10:0] vc,
                                     input logic [10:0] gx, input logic [3:0] dig);
    logic [10:0] rx, ry;
    logic [6:0]  m;
    logic        in_box, upper, left, right;
    case (dig)
      4'd0:    m = 7'b1111110;
      4'd1:    m = 7'b0110000;
      4'd2:    m = 7'b1101101;
      4'd3:    m = 7'b1111001;
      4'd4:    m = 7'b0110011;
      4'd5:    m = 7'b1011011;
      4'd6:    m = 7'b1011111;
      4'd7:    m = 7'b1110000;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1111011;
      default: m = 7'b0000000;
    endcase
    in_box = (hc >= gx) && (hc < gx + W) && (vc >= Y0) && (vc < Y0 + H);
    rx     = hc - gx;
    ry     = vc - Y0;
    upper  = ry < HALF;
    left   = rx < T;
    right  = rx >= R_START;
    return in_box & ((m[6] & (ry < T)) |
                     (m[5] & right & upper) |
                     (m[4] & right & ~upper) |
                     (m[3] & (ry >= D_START)) |
                     (m[2] & left & ~upper) |
                     (m[1] & left & upper) |
                     (m[0] & (ry >= G_START) & (ry < G_END)));
  endfunction

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (vs_edge) state_next = CONV;
      CONV:    if (m_s < 6'd10 && s_s < 6'd10) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot registers double as the working remainders during conversion.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_prev <= 1'b0;
      m_s     <= '0;
      s_s     <= '0;
      m_tens  <= '0;
      s_tens  <= '0;
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      d3      <= '0;
    end else begin
      vs_prev <= vga_in[37];
      case (state)
        IDLE: if (vs_edge) begin
          m_s    <= minutes;
          s_s    <= seconds;
          m_tens <= '0;
          s_tens <= '0;
        end
        CONV: begin
          if (m_s >= 6'd10) begin
            m_s    <= m_s - 6'd10;
            m_tens <= m_tens + 3'd1;
          end
          if (s_s >= 6'd10) begin
            s_s    <= s_s - 6'd10;
            s_tens <= s_tens + 3'd1;
          end
        end
        DONE: begin
          d0 <= {1'b0, m_tens};
          d1 <= m_s[3:0];
          d2 <= {1'b0, s_tens};
          d3 <= s_s[3:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hit[0] = digit_hit(vga_in[22:12], vga_in[33:23], X0, d0);
    hit[1] = digit_hit(vga_in[22:12], vga_in[33:23], X1, d1);
    hit[2] = digit_hit(vga_in[22:12], vga_in[33:23], X2, d2);
    hit[3] = digit_hit(vga_in[22:12], vga_in[33:23], X3, d3);
    hit[4] = (vga_in[22:12] >= XC) && (vga_in[22:12] < XC + T) &&
             (vga_in[33:23] >= Y0) && (vga_in[33:23] < Y0 + H) &&
             (((vga_in[33:23] - Y0) >= C0_START && (vga_in[33:23] - Y0) < C0_END) ||
              ((vga_in[33:23] - Y0) >= C1_START && (vga_in[33:23] - Y0) < C1_END));
  end

  assign draw = en_s1 & ~bus_s1[35] & ~bus_s1[34] & (|hit_s1);

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus_s1  <= '0;
      hit_s1  <= '0;
      en_s1   <= 1'b0;
      vga_out <= '0;
    end else begin
      bus_s1  <= vga_in;
      hit_s1  <= hit;
      en_s1   <= enable;
      vga_out <= {bus_s1[37:12], draw ? COLOR : bus_s1[11:0]};
    end
  end

endmodule

// File: tb/tb_draw_stopwatch.sv
// Randomized bench for draw_stopwatch against a geometric model of the "MM:SS" overlay.
module tb_draw_stopwatch;

  localparam int X_POS = 16, Y_POS = 16, DIGIT_W = 24, DIGIT_H = 40, SEG_T = 4, GAP = 8;
  localparam int P = DIGIT_W + GAP;
  localparam logic [11:0] COLOR = 12'hFF0;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  minutes = '0, seconds = '0;
  logic [37:0] vga_in = '0;
  logic [37:0] vga_out;

  int vectors = 0, miscompares = 0;

  logic [37:0] s1_val = '0, s2_val = '0;
  bit          s1_dc = 0, s2_dc = 0, prev_vs = 0;
  int          shown_m = 0, shown_s = 0, dc_left = 0;

  string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  draw_stopwatch dut (
    .pclk(pclk), .rst(rst), .enable(enable), .minutes(minutes),
    .seconds(seconds), .vga_in(vga_in), .vga_out(vga_out)
  );

  always #5 pclk = ~pclk;

  task automatic check_output(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void seg_rect(input byte c, output int x0, output int x1,
                                   output int y0, output int y1);
    x0 = 0; x1 = DIGIT_W; y0 = 0; y1 = DIGIT_H / 2;
    case (c)
      "a": begin y1 = SEG_T; end
      "b": begin x0 = DIGIT_W - SEG_T; end
      "c": begin x0 = DIGIT_W - SEG_T; y0 = DIGIT_H / 2; y1 = DIGIT_H; end
      "d": begin y0 = DIGIT_H - SEG_T; y1 = DIGIT_H; end
      "e": begin x1 = SEG_T; y0 = DIGIT_H / 2; y1 = DIGIT_H; end
      "f": begin x1 = SEG_T; end
      "g": begin y0 = DIGIT_H / 2 - SEG_T / 2; y1 = DIGIT_H / 2 + SEG_T / 2; end
      default: begin x1 = 0; end
    endcase
  endfunction

  function automatic bit model_hit(input int x, input int y, input int mm, input int ss);
    int dig[4];
    int ox[4];
    int lx, ly, x0, x1, y0, y1;
    string s;
    dig = '{mm / 10, mm % 10, ss / 10, ss % 10};
    ox  = '{X_POS, X_POS + P, X_POS + 2 * P + SEG_T + GAP, X_POS + 3 * P + SEG_T + GAP};
    ly  = y - Y_POS;
    for (int g = 0; g < 4; g++) begin
      lx = x - ox[g];
      s  = segs[dig[g]];
      for (int i = 0; i < s.len(); i++) begin
        seg_rect(s[i], x0, x1, y0, y1);
        if (lx >= x0 && lx < x1 && ly >= y0 && ly < y1) return 1'b1;
      end
    end
    lx = x - (X_POS + 2 * P);
    if (lx >= 0 && lx < SEG_T &&
        ((ly >= DIGIT_H / 4 - SEG_T / 2 && ly < DIGIT_H / 4 + SEG_T / 2) ||
         (ly >= 3 * DIGIT_H / 4 - SEG_T / 2 && ly < 3 * DIGIT_H / 4 + SEG_T / 2)))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [37:0] make_bus(input bit vs, input bit vb, input bit hb,
                                           input int x, input int y, input logic [11:0] rgb);
    return {vs, 1'($urandom_range(0, 1)), vb, hb, 11'(y), 11'(x), rgb};
  endfunction

  // One pixel clock: drive, advance the two-deep reference pipeline, compare.
  task automatic apply_stimulus(input logic [37:0] bus, input bit en, input bit r);
    logic [37:0] e;
    vga_in = bus;
    enable = en;
    rst    = r;
    @(posedge pclk);
    s2_val = r ? '0 : s1_val;
    s2_dc  = r ? 1'b0 : s1_dc;
    if (r) begin
      s1_val = '0; s1_dc = 0; shown_m = 0; shown_s = 0; prev_vs = 0; dc_left = 0;
    end else begin
      if (bus[37] && !prev_vs) begin
        shown_m = int'(minutes);
        shown_s = int'(seconds);
        dc_left = 9;
      end
      prev_vs = bus[37];
      e = bus;
      if (en && !bus[35] && !bus[34] &&
          model_hit(int'(bus[22:12]), int'(bus[33:23]), shown_m, shown_s))
        e[11:0] = COLOR;
      s1_val = e;
      s1_dc  = (dc_left > 0);
      if (dc_left > 0) dc_left--;
    end
    @(negedge pclk);
    if (s2_dc) check_output("bus_fields", {vga_out[37:12], 12'h000}, {s2_val[37:12], 12'h000});
    else       check_output("bus", vga_out, s2_val);
  endtask

  task automatic idle_cycle(input bit vs);
    apply_stimulus(make_bus(vs, 0, 0, 600, 600, 12'h000), 1'b1, 1'b0);
  endtask

  task automatic random_cycle();
    int x, y;
    if ($urandom_range(0, 15) == 0) begin
      x = int'($urandom_range(0, 2047));
      y = int'($urandom_range(0, 2047));
    end else begin
      x = int'($urandom_range(0, 175));
      y = int'($urandom_range(0, 70));
    end
    apply_stimulus(make_bus(0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                            x, y, 12'($urandom)), $urandom_range(0, 3) != 0, 1'b0);
  endtask

  task automatic new_frame(input int m, input int s);
    minutes = 6'(m);
    seconds = 6'(s);
    repeat (3) idle_cycle(1'b1);
    repeat (10) idle_cycle(1'b0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [11:0] bg,
                       input bit en, input bit hb, input bit vb, input logic [11:0] exp);
    apply_stimulus(make_bus(0, vb, hb, x, y, bg), en, 1'b0);
    idle_cycle(1'b0);
    check_output(tag, {26'h0, vga_out[11:0]}, {26'h0, exp});
  endtask

  initial begin
    repeat (3) apply_stimulus(make_bus(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                       int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                                       12'($urandom)), 1'b1, 1'b1);
    repeat (10) random_cycle();

    new_frame(3, 47);
    probe("d0_seg_a", 18, 17, 12'h123, 1, 0, 0, COLOR);
    repeat (100) random_cycle();

    new_frame(0, 1);
    probe("d3_one_a", X_POS + 3 * P + SEG_T + GAP + 12, 17, 12'h0A5, 1, 0, 0, 12'h0A5);
    probe("d3_one_b", X_POS + 3 * P + SEG_T + GAP + 22, 20, 12'h0A5, 1, 0, 0, COLOR);

    new_frame(63, 63);
    probe("d0_six_a", 18, 17, 12'h321, 1, 0, 0, COLOR);
    probe("d1_three_f", X_POS + P + 1, 22, 12'h321, 1, 0, 0, 12'h321);
    probe("d2_six_f", X_POS + 2 * P + SEG_T + GAP + 1, 30, 12'h321, 1, 0, 0, COLOR);
    minutes = 6'd5;
    seconds = 6'd0;
    repeat (50) random_cycle();
    probe("hold_midframe", X_POS + P + 1, 22, 12'h321, 1, 0, 0, 12'h321);
    new_frame(5, 0);
    probe("d1_five_f", X_POS + P + 1, 22, 12'h321, 1, 0, 0, COLOR);

    probe("enable_off", X_POS + P + 1, 22, 12'h456, 0, 0, 0, 12'h456);
    probe("hblank", X_POS + P + 1, 22, 12'h456, 1, 1, 0, 12'h456);
    probe("vblank", X_POS + P + 1, 22, 12'h456, 1, 0, 1, 12'h456);

    probe("colon_on", X_POS + 64 + 1, 16 + 10, 12'h789, 1, 0, 0, COLOR);
    probe("colon_off", X_POS + 64 + 1, 16 + 20, 12'h789, 1, 0, 0, 12'h789);

    new_frame(5, 8);
    probe("d3_eight_g", X_POS + 3 * P + SEG_T + GAP + 10, 35, 12'h0F0, 1, 0, 0, COLOR);
    repeat (2) apply_stimulus(make_bus(0, 0, 0, 600, 600, 12'h000), 1'b1, 1'b1);
    probe("rst_zero_g", X_POS + 3 * P + SEG_T + GAP + 10, 35, 12'h0F0, 1, 0, 0, 12'h0F0);
    probe("rst_zero_a", 18, 17, 12'h0F0, 1, 0, 0, COLOR);

    repeat (6) begin
      new_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      repeat (150) begin
        if ($urandom_range(0, 63) == 0) begin
          minutes = 6'($urandom_range(0, 63));
          seconds = 6'($urandom_range(0, 63));
        end
        random_cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
